// File: rtl/renode_apb3_manager_bridge_pkg.sv
// Shared types for the APB3 manager bridge: FSM state, response record and
// the timeout-counter width rule.
package renode_apb3_manager_bridge_pkg;

    localparam int unsigned MaxDataWidth = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb3_mgr_state_e;

    typedef struct packed {
        logic [MaxDataWidth-1:0] rdata;
        logic                    err;
        logic                    timeout;
    } apb3_rsp_t;

    // A limit of 0 disables the timeout, but the counter still needs one bit.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return (limit == 0) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/renode_apb3_manager_bridge_if.sv
// Request/response channel plus APB3 signals seen by the manager bridge.
interface renode_apb3_manager_bridge_if #(
    parameter int AddressWidth = 20,
    parameter int DataWidth    = 32
);
    logic                    req_valid;
    logic                    req_ready;
    logic [AddressWidth-1:0] req_addr;
    logic                    req_write;
    logic [DataWidth-1:0]    req_wdata;

    logic                    rsp_valid;
    logic                    rsp_ready;
    logic [DataWidth-1:0]    rsp_rdata;
    logic                    rsp_err;
    logic                    rsp_timeout;

    logic [AddressWidth-1:0] paddr;
    logic                    pselx;
    logic                    penable;
    logic                    pwrite;
    logic [DataWidth-1:0]    pwdata;
    logic [DataWidth-1:0]    prdata;
    logic                    pready;
    logic                    pslverr;

    modport master (
        input  req_valid, req_addr, req_write, req_wdata, rsp_ready,
               prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               paddr, pselx, penable, pwrite, pwdata
    );

    modport slave (
        output req_valid, req_addr, req_write, req_wdata, rsp_ready,
               prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
               paddr, pselx, penable, pwrite, pwdata
    );
endinterface

// File: rtl/renode_apb3_manager_bridge_timeout_counter.sv
// Counts ACCESS cycles without pready; flags the last allowed cycle.
module renode_apb3_timeout_counter
    import renode_apb3_manager_bridge_pkg::*;
#(
    parameter int unsigned Limit = 256
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int unsigned CW = cnt_width(Limit);
    localparam logic [CW-1:0] LAST = (Limit == 0) ? '0 : CW'(Limit - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                    cnt <= '0;
        else if (clear)                cnt <= '0;
        else if (enable && cnt != '1)  cnt <= cnt + CW'(1);
    end

    assign expired = (Limit != 0) && (cnt == LAST);
endmodule

// File: rtl/renode_apb3_manager_bridge.sv
// Valid/ready request channel to APB3 manager: SETUP/ACCESS sequencing,
// wait states, PSLVERR, misalignment rejection and bounded-wait timeout.
module renode_apb3_manager_bridge
    import renode_apb3_manager_bridge_pkg::*;
#(
    parameter int AddressWidth  = 20,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 256
) (
    input  logic pclk,
    input  logic presetn,
    renode_apb3_manager_bridge_if.master bus
);
    localparam int LSB = $clog2(DataWidth / 8);
    localparam logic [AddressWidth-1:0] AMASK = AddressWidth'((1 << LSB) - 1);

    apb3_mgr_state_e state, state_nxt;
    apb3_rsp_t       rsp_q, rsp_d;
    logic            load_bus, cnt_clear, cnt_en, expired;
    logic            accept, misaligned;

    assign accept     = bus.req_valid && bus.req_ready;
    assign misaligned = |(bus.req_addr & AMASK);

    always_comb begin
        state_nxt = state;
        rsp_d     = rsp_q;
        load_bus  = 1'b0;
        cnt_clear = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        rsp_d     = '{rdata: '0, err: 1'b1, timeout: 1'b0};
                        state_nxt = RESP;
                    end else begin
                        load_bus  = 1'b1;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                cnt_clear = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (bus.pready) begin
                    // Error reads return zero rather than whatever the completer drove.
                    rsp_d.rdata   = (!bus.pwrite && !bus.pslverr) ?
                                    MaxDataWidth'(bus.prdata) : '0;
                    rsp_d.err     = bus.pslverr;
                    rsp_d.timeout = 1'b0;
                    state_nxt     = RESP;
                end else if (expired) begin
                    rsp_d     = '{rdata: '0, err: 1'b1, timeout: 1'b1};
                    state_nxt = RESP;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
            rsp_q <= '0;
        end else begin
            state <= state_nxt;
            rsp_q <= rsp_d;
        end
    end

    // Bus address/data only move on a real transfer, so they hold across rejects.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            bus.paddr  <= '0;
            bus.pwrite <= 1'b0;
            bus.pwdata <= '0;
        end else if (load_bus) begin
            bus.paddr  <= bus.req_addr;
            bus.pwrite <= bus.req_write;
            bus.pwdata <= bus.req_wdata;
        end
    end

    assign bus.req_ready   = presetn && (state == IDLE);
    assign bus.pselx       = (state == SETUP) || (state == ACCESS);
    assign bus.penable     = (state == ACCESS);
    assign bus.rsp_valid   = (state == RESP);
    assign bus.rsp_rdata   = rsp_q.rdata[DataWidth-1:0];
    assign bus.rsp_err     = rsp_q.err;
    assign bus.rsp_timeout = rsp_q.timeout;

    renode_apb3_timeout_counter #(.Limit(TimeoutCycles)) u_tmo (
        .clk     (pclk),
        .rst_n   (presetn),
        .clear   (cnt_clear),
        .enable  (cnt_en),
        .expired (expired)
    );
endmodule
